// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: opcode constants, instruction field slices,
// the fetch FSM state type and the branch-offset helper.
package fetch_unit_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam int OPCODE_HI   = 31;
  localparam int OPCODE_LO   = 26;
  localparam int FUNC_HI     = 5;
  localparam int FUNC_LO     = 0;
  localparam int IMM16_HI    = 15;
  localparam int IMM16_LO    = 0;
  localparam int TARGET26_HI = 25;
  localparam int TARGET26_LO = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Word-scaled, sign-extended conditional branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch stage: redirect mux with
// priority jump_register > jump > branch > sequential, plus the link value.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       target26,
  input  logic              jump,
  input  logic              jump_register,
  input  logic              branch,
  input  logic [31:0]       rs_data,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus8
);

  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] jump_target_s;
  logic [ADDR_W-1:0] branch_target_s;

  assign pc_plus4_s      = pc + ADDR_W'(32'd4);
  assign pc_plus8        = pc + ADDR_W'(32'd8);
  assign jump_target_s   = {pc_plus4_s[ADDR_W-1:28], target26, 2'b00};
  assign branch_target_s = pc_plus4_s + ADDR_W'(branch_offset(target26[IMM16_HI:IMM16_LO]));

  // Redirect priority mux; halted is resolved by the FSM ahead of this.
  always_comb begin
    next_pc = pc_plus4_s;
    if (jump_register) begin
      next_pc = ADDR_W'(rs_data);
    end else if (jump) begin
      next_pc = jump_target_s;
    end else if (branch) begin
      next_pc = branch_target_s;
    end else begin
      next_pc = pc_plus4_s;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over imem req/ack and hands
// words to decode. Optional misaligned-target trap: FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus8,
  input  logic              branch,
  input  logic              jump,
  input  logic              jump_register,
  input  logic              halted,
  input  logic [31:0]       rs_data,
  output logic              fetch_halted,
  output logic              fetch_fault
);

  fetch_state_e      state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [31:0]       inst_r, inst_s;
  logic [ADDR_W-1:0] next_pc_s;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
    .pc            (pc_r),
    .target26      (inst_r[TARGET26_HI:TARGET26_LO]),
    .jump          (jump),
    .jump_register (jump_register),
    .branch        (branch),
    .rs_data       (rs_data),
    .next_pc       (next_pc_s),
    .pc_plus8      (pc_plus8)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_r, fault_s;

  // Sticky misaligned-target flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_s;
    end
  end

  assign fetch_fault = fault_r && !rst;
`else
  assign fetch_fault = 1'b0;
`endif

  // State, PC and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      inst_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      inst_r  <= inst_s;
    end
  end

  // Next-state logic; acks outside FETCH and inst_ready outside ISSUE fall through.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    inst_s  = inst_r;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_s = fault_r;
`endif
    case (state_r)
      ST_FETCH: begin
        if (imem_ack) begin
          inst_s  = imem_rdata;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (!inst_ready) begin
          state_s = ST_ISSUE;
        end else if (halted) begin
          state_s = ST_HALT;
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
          pc_s = next_pc_s;
          if (next_pc_s[1:0] != 2'b00) begin
            state_s = ST_HALT;
            fault_s = 1'b1;
          end else begin
            state_s = ST_FETCH;
          end
`else
          pc_s    = next_pc_s & ~ADDR_W'(32'd3);
          state_s = ST_FETCH;
`endif
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_FETCH;
      end
    endcase
  end

  // Outputs are forced quiet while rst is held.
  assign imem_req     = (state_r == ST_FETCH) && !rst;
  assign inst_valid   = (state_r == ST_ISSUE) && !rst;
  assign fetch_halted = (state_r == ST_HALT) && !rst;
  assign imem_addr    = pc_r;
  assign pc           = pc_r;
  assign inst         = inst_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential run, branches,
// jump priority, wrap, stalls, reset mid-wait, alignment and halt.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        branch;
  logic        jump;
  logic        jump_register;
  logic        halted;
  logic [31:0] rs_data;
  logic        fetch_halted;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc),
    .pc_plus8      (pc_plus8),
    .branch        (branch),
    .jump          (jump),
    .jump_register (jump_register),
    .halted        (halted),
    .rs_data       (rs_data),
    .fetch_halted  (fetch_halted),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    inst_ready = 1'b0; branch = 1'b0; jump = 1'b0;
    jump_register = 1'b0; halted = 1'b0; rs_data = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    clear_ctl();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge while in FETCH; ack after lat waiting cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, a);
    for (int i = 0; i < lat; i++) begin
      inst_ready = 1'b1; branch = 1'b1;
      @(negedge clk);
      clear_ctl();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, a);
      chk("wait_valid", 32'(inst_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk("valid", 32'(inst_valid), 32'd1);
    chk("inst", inst, d);
    chk("pc", pc, a);
    chk("pc_plus8", pc_plus8, a + 32'd8);
    chk("req_issue", 32'(imem_req), 32'd0);
  endtask

  // Called at a negedge while in ISSUE; stall, then accept with redirects.
  task automatic issue(input logic br, input logic j, input logic jr, input logic h,
                       input logic [31:0] rs, input int stall);
    logic [31:0] i0, p0;
    i0 = inst; p0 = pc;
    for (int i = 0; i < stall; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, i0);
      chk("stall_pc", pc, p0);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    inst_ready = 1'b1; branch = br; jump = j; jump_register = jr; halted = h; rs_data = rs;
    @(negedge clk);
    clear_ctl();
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_halted", 32'(fetch_halted), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sequential run, ack in the request cycle.
    fetch(32'h0, 32'h2001_0001, 0);  issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h4, 32'h2002_0002, 0);  issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h8, 32'h2003_0003, 0);  issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'hC, 32'h2004_0004, 0);  issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Branches from 0x10: back by 16, forward by 12.
    fetch(32'h10, 32'h1000_FFFC, 0); issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h04, 32'h0000_0000, 0); issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 0);
    fetch(32'h10, 32'h1000_0003, 0); issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h20, 32'h0000_0000, 0); issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0040, 0);

    // Jump vs JR priority, then jump beating branch.
    fetch(32'h1000_0040, 32'h0800_0040, 0); issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 0);
    fetch(32'h0000_0200, 32'h0000_0000, 0); issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0040, 0);
    fetch(32'h1000_0040, 32'h0800_0040, 0); issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h1000_0100, 32'h0000_0000, 0); issue(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 0);

    // Sequential wrap, then 3-cycle ack latency and 5-cycle stall.
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0); issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h0, 32'h2005_0005, 3);         issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5);

    // Reset mid-wait with a coincident stale ack.
    chk("pre_rst_addr", imem_addr, 32'h4);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_inst", inst, 32'h0);

    // Misaligned JR target.
    fetch(32'h0, 32'h2006_0006, 1); issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      chk("align_fault", 32'(fetch_fault), 32'd1);
      chk("align_halted", 32'(fetch_halted), 32'd1);
      chk("align_req", 32'(imem_req), 32'd0);
      chk("align_pc", pc, 32'h0000_0102);
      @(negedge clk);
    end
`else
    chk("align_fault", 32'(fetch_fault), 32'd0);
    fetch(32'h0000_0100, 32'h2007_0007, 0); issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
`endif

    // Halt beats JR; sticky until reset.
    do_reset();
    @(negedge clk);
    fetch(32'h0, 32'h0000_000C, 0); issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 0);
    for (int i = 0; i < 4; i++) begin
      chk("halt_flag", 32'(fetch_halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(inst_valid), 32'd0);
      chk("halt_pc", pc, 32'h0);
      chk("halt_fault", 32'(fetch_fault), 32'd0);
      imem_ack = 1'b1; inst_ready = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0; inst_ready = 1'b0;
    end
    do_reset();
    @(negedge clk);
    chk("post_halt_rst_req", 32'(imem_req), 32'd1);
    chk("post_halt_rst_flag", 32'(fetch_halted), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
